// File: rtl/period_meter.sv
// rtl/period_meter.sv - averaged period / high-time meter for an asynchronous input
//
// Measures the period and high time of sig_in in clk cycles, averaged over
// 2**AVG_LOG2 consecutive periods, with a no-edge timeout.
//
// Ports:
//   clk        in   1      single clock, posedge
//   rst        in   1      asynchronous active-high reset
//   en         in   1      measurement enable
//   sig_in     in   1      asynchronous signal under measurement
//   period     out  CNT_W  averaged period in clk cycles
//   high_time  out  CNT_W  averaged high time in clk cycles
//   valid      out  1      one-cycle pulse when period/high_time update
//   timeout    out  1      one-cycle pulse when no rising edge for 2**CNT_W-1 cycles
//   busy       out  1      high while arming or measuring
module period_meter #(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    // n needs at least one bit even when no averaging is done
    localparam int N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int NUM   = 1 << AVG_LOG2;
    localparam logic [N_W-1:0] N_LAST = N_W'(NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS
    } state_t;

    state_t state, state_next;

    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt, hcnt;
    logic [ACC_W-1:0] acc_p, acc_h;
    logic [ACC_W-1:0] sum_p, sum_h;
    logic [N_W-1:0]   n;
    logic             cnt_max;
    logic             window_done;
    logic             timeout_hit;

    // two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign cnt_max = &cnt;

    // the closing sample is added here so the result includes the current rise
    assign sum_p = acc_p + ACC_W'(cnt);
    assign sum_h = acc_h + ACC_W'(hcnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (en) state_next = S_ARM;
            S_ARM: begin
                if (!en)       state_next = S_IDLE;
                else if (rise) state_next = S_MEAS;
            end
            S_MEAS: begin
                if (!en)                  state_next = S_IDLE;
                else if (!rise && cnt_max) state_next = S_ARM;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == S_ARM) || (state == S_MEAS);
        window_done = (state == S_MEAS) && en && rise && (n == N_LAST);
        // a rise in the same cycle takes priority over the timeout
        timeout_hit = (state == S_MEAS) && en && !rise && cnt_max;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            hcnt      <= '0;
            acc_p     <= '0;
            acc_h     <= '0;
            n         <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= window_done;
            timeout <= timeout_hit;
            case (state)
                S_IDLE: begin
                    cnt   <= '0;
                    hcnt  <= '0;
                    acc_p <= '0;
                    acc_h <= '0;
                    n     <= '0;
                end
                S_ARM: begin
                    if (en && rise) begin
                        cnt   <= CNT_W'(1);
                        hcnt  <= CNT_W'(1);
                        acc_p <= '0;
                        acc_h <= '0;
                        n     <= '0;
                    end
                end
                S_MEAS: begin
                    if (en) begin
                        if (rise) begin
                            cnt  <= CNT_W'(1);
                            hcnt <= CNT_W'(1);
                            if (n == N_LAST) begin
                                period    <= sum_p[AVG_LOG2 +: CNT_W];
                                high_time <= sum_h[AVG_LOG2 +: CNT_W];
                                acc_p     <= '0;
                                acc_h     <= '0;
                                n         <= '0;
                            end else begin
                                acc_p <= sum_p;
                                acc_h <= sum_h;
                                n     <= n + N_W'(1);
                            end
                        end else if (!cnt_max) begin
                            cnt  <= cnt + CNT_W'(1);
                            hcnt <= hcnt + CNT_W'(s2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
module tb_period_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sig_in = 1'b0;

    logic [15:0] period, high_time;
    logic        valid, timeout, busy;
    logic [7:0]  period8, high_time8;
    logic        valid8, timeout8, busy8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0, t1;
    int vq_t[$], vq_p[$], vq_h[$], tq_t[$];
    int v8_t[$], v8_p[$], v8_h[$], t8_t[$];
    bit both_seen = 1'b0;

    period_meter #(.CNT_W(16), .AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period), .high_time(high_time),
        .valid(valid), .timeout(timeout), .busy(busy)
    );

    period_meter #(.CNT_W(8), .AVG_LOG2(2)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period8), .high_time(high_time8),
        .valid(valid8), .timeout(timeout8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // event log: cyc here is the index of the posedge that produced the outputs
    always @(negedge clk) begin
        if (valid) begin
            vq_t.push_back(cyc); vq_p.push_back(int'(period)); vq_h.push_back(int'(high_time));
        end
        if (timeout) tq_t.push_back(cyc);
        if (valid8) begin
            v8_t.push_back(cyc); v8_p.push_back(int'(period8)); v8_h.push_back(int'(high_time8));
        end
        if (timeout8) t8_t.push_back(cyc);
        if ((valid && timeout) || (valid8 && timeout8)) both_seen = 1'b1;
    end

    task automatic clear_logs();
        vq_t.delete(); vq_p.delete(); vq_h.delete(); tq_t.delete();
        v8_t.delete(); v8_p.delete(); v8_h.delete(); t8_t.delete();
    endtask

    // reset, then enable and let the meter reach ARM; ends on a negedge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // n periods of hi cycles high then lo cycles low, starting on a negedge
    task automatic wave(input int hi, input int lo, input int nper);
        repeat (nper) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({period, high_time, valid, timeout, busy} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got p=%0d h=%0d v=%0b t=%0b b=%0b want all 0",
                     period, high_time, valid, timeout, busy);
        end
        do_reset();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_arm_busy got %0b want 1", busy);
        end
    endtask

    // 6 high / 6 low: sig_in edge -> consumed rise on 3rd edge, valid 48 edges later
    task automatic test_square();
        do_reset();
        t0 = cyc;
        wave(6, 6, 9);
        checks++;
        if (vq_t.size() != 2) begin
            failures++;
            $display("FAIL square_valid_count got %0d want 2", vq_t.size());
        end
        checks++;
        if (vq_t.size() < 1 || vq_t[0] != t0 + 51) begin
            failures++;
            $display("FAIL square_first_valid got %0d want %0d", vq_t.size() ? vq_t[0] - t0 : -1, 51);
        end
        checks++;
        if (vq_t.size() < 2 || vq_t[1] != t0 + 99) begin
            failures++;
            $display("FAIL square_second_valid got %0d want %0d", vq_t.size() > 1 ? vq_t[1] - t0 : -1, 99);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (vq_p.size() <= i || vq_p[i] != 12 || vq_h[i] != 6) begin
                failures++;
                $display("FAIL square_values[%0d] got p=%0d h=%0d want p=12 h=6", i,
                         vq_p.size() > i ? vq_p[i] : -1, vq_h.size() > i ? vq_h[i] : -1);
            end
        end
    endtask

    task automatic test_duty();
        do_reset();
        t0 = cyc;
        wave(3, 9, 5);
        checks++;
        if (vq_t.size() != 1 || vq_t[0] != t0 + 51 || vq_p[0] != 12 || vq_h[0] != 3) begin
            failures++;
            $display("FAIL duty_3_9 got n=%0d p=%0d h=%0d want n=1 p=12 h=3", vq_t.size(),
                     vq_p.size() ? vq_p[0] : -1, vq_h.size() ? vq_h[0] : -1);
        end
    endtask

    // periods 11,12,13,13 (high 5,6,6,6): sums 49 and 23 -> 12 and 5
    task automatic test_truncate();
        do_reset();
        t0 = cyc;
        wave(5, 6, 1);
        wave(6, 6, 1);
        wave(6, 7, 2);
        wave(6, 6, 1);
        checks++;
        if (vq_t.size() != 1 || vq_t[0] != t0 + 52 || vq_p[0] != 12 || vq_h[0] != 5) begin
            failures++;
            $display("FAIL truncate got n=%0d t=%0d p=%0d h=%0d want n=1 t=52 p=12 h=5", vq_t.size(),
                     vq_t.size() ? vq_t[0] - t0 : -1, vq_p.size() ? vq_p[0] : -1,
                     vq_h.size() ? vq_h[0] : -1);
        end
    endtask

    // CNT_W=8: last rise consumed at t0+51, timeout 255 edges later
    task automatic test_timeout();
        do_reset();
        t0 = cyc;
        wave(6, 6, 5);
        repeat (300) @(negedge clk);
        checks++;
        if (t8_t.size() != 1 || t8_t[0] != t0 + 306) begin
            failures++;
            $display("FAIL timeout_pulse got n=%0d t=%0d want n=1 t=306", t8_t.size(),
                     t8_t.size() ? t8_t[0] - t0 : -1);
        end
        checks++;
        if (v8_t.size() != 1 || period8 !== 8'd12 || high_time8 !== 8'd6) begin
            failures++;
            $display("FAIL timeout_hold got n=%0d p=%0d h=%0d want n=1 p=12 h=6",
                     v8_t.size(), period8, high_time8);
        end
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL timeout_busy got %0b want 1", busy8);
        end
        t1 = cyc;
        wave(6, 6, 5);
        checks++;
        if (v8_t.size() != 2 || v8_t[1] != t1 + 51 || v8_p[1] != 12) begin
            failures++;
            $display("FAIL timeout_resume got n=%0d t=%0d want n=2 t=51", v8_t.size(),
                     v8_t.size() > 1 ? v8_t[1] - t1 : -1);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        t0 = cyc;
        wave(6, 6, 7);
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || period !== 16'd12 || high_time !== 16'd6) begin
            failures++;
            $display("FAIL en_drop_idle got b=%0b p=%0d h=%0d want b=0 p=12 h=6", busy, period, high_time);
        end
        repeat (18) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        t1 = cyc;
        wave(3, 9, 5);
        checks++;
        if (vq_t.size() != 2 || vq_t[1] != t1 + 51 || vq_p[1] != 12 || vq_h[1] != 3) begin
            failures++;
            $display("FAIL en_drop_rearm got n=%0d t=%0d p=%0d h=%0d want n=2 t=51 p=12 h=3",
                     vq_t.size(), vq_t.size() > 1 ? vq_t[1] - t1 : -1,
                     vq_p.size() > 1 ? vq_p[1] : -1, vq_h.size() > 1 ? vq_h[1] : -1);
        end
        checks++;
        if (tq_t.size() != 0) begin
            failures++;
            $display("FAIL en_drop_timeout got %0d want 0", tq_t.size());
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        wave(6, 6, 7);
        rst = 1'b1;
        #1;
        checks++;
        if ({period, high_time, valid, timeout, busy} !== 35'd0) begin
            failures++;
            $display("FAIL rst_mid got p=%0d h=%0d v=%0b t=%0b b=%0b want all 0",
                     period, high_time, valid, timeout, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);
        t0 = cyc;
        wave(6, 6, 5);
        checks++;
        if (vq_t.size() != 1 || vq_t[0] != t0 + 51 || vq_p[0] != 12 || vq_h[0] != 6) begin
            failures++;
            $display("FAIL rst_mid_restart got n=%0d t=%0d want n=1 t=51", vq_t.size(),
                     vq_t.size() ? vq_t[0] - t0 : -1);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_seen) begin
            failures++;
            $display("FAIL valid_timeout_overlap got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_truncate();
        test_timeout();
        test_enable_drop();
        test_rst_mid();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
